// File: rtl/knn_query_controller.sv
// k-nearest-neighbour query sequencer: fetches each training point, feeds the
// external distance unit, keeps a sorted K-entry list and majority-votes a label.
module knn_query_controller #(
  parameter int SIZE      = 32,
  parameter int DIMENSION = 3,
  parameter int N_POINTS  = 16,
  parameter int K         = 3,
  parameter int LABEL_W   = 2,
  localparam int AW       = (N_POINTS > 1) ? $clog2(N_POINTS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [DIMENSION-1:0][SIZE-1:0]      query,
  output logic                                busy,
  output logic                                done,
  output logic                                mem_rd,
  output logic [AW-1:0]                       mem_addr,
  input  logic [DIMENSION-1:0][SIZE-1:0]      mem_point,
  input  logic [LABEL_W-1:0]                  mem_label,
  output logic [DIMENSION-1:0][SIZE-1:0]      dist_p,
  output logic [DIMENSION-1:0][SIZE-1:0]      dist_q,
  input  logic [SIZE-1:0]                     dist_val,
  output logic [K-1:0][SIZE-1:0]              nn_dist,
  output logic [K-1:0][LABEL_W-1:0]           nn_label,
  output logic [K-1:0]                        nn_valid,
  output logic [LABEL_W-1:0]                  result_label
);

  localparam int CW = $clog2(K + 1);
  localparam int NL = 2 ** LABEL_W;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_INSERT, S_VOTE, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [AW-1:0]                     i_q, i_d;
  logic [DIMENSION-1:0][SIZE-1:0]    qry_q, qry_d;
  logic [DIMENSION-1:0][SIZE-1:0]    pnt_q, pnt_d;
  logic [LABEL_W-1:0]                lbl_q, lbl_d;
  logic [K-1:0][SIZE-1:0]            nnd_q, nnd_d;
  logic [K-1:0][LABEL_W-1:0]         nnl_q, nnl_d;
  logic [K-1:0]                      nnv_q, nnv_d;
  logic [LABEL_W-1:0]                res_q, res_d;

  logic                              ins_found;
  int                                ins_pos;
  logic [K-1:0][SIZE-1:0]            sh_dist;
  logic [K-1:0][LABEL_W-1:0]         sh_label;
  logic [K-1:0]                      sh_valid;
  logic [NL-1:0][CW-1:0]             cnt;
  logic [CW-1:0]                     best_cnt;
  logic [LABEL_W-1:0]                best_lbl;

  // Strict less-than keeps an earlier point ahead of a later one at equal distance.
  always_comb begin
    ins_found = 1'b0;
    ins_pos   = 0;
    for (int j = 0; j < K; j++) begin
      if (!ins_found && (!nnv_q[j] || (dist_val < nnd_q[j]))) begin
        ins_found = 1'b1;
        ins_pos   = j;
      end
    end
    sh_dist  = nnd_q;
    sh_label = nnl_q;
    sh_valid = nnv_q;
    for (int j = K - 1; j >= 1; j--) begin
      if (j > ins_pos) begin
        sh_dist[j]  = nnd_q[j-1];
        sh_label[j] = nnl_q[j-1];
        sh_valid[j] = nnv_q[j-1];
      end
    end
    for (int j = 0; j < K; j++) begin
      if (j == ins_pos) begin
        sh_dist[j]  = dist_val;
        sh_label[j] = lbl_q;
        sh_valid[j] = 1'b1;
      end
    end
  end

  // Ascending scan with strict greater-than: a count tie keeps the smaller label.
  always_comb begin
    cnt      = '0;
    best_cnt = '0;
    best_lbl = '0;
    for (int v = 0; v < NL; v++) begin
      for (int e = 0; e < K; e++) begin
        if (nnv_q[e] && (nnl_q[e] == LABEL_W'(v))) cnt[v] = cnt[v] + CW'(1);
      end
      if (cnt[v] > best_cnt) begin
        best_cnt = cnt[v];
        best_lbl = LABEL_W'(v);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    qry_d   = qry_q;
    pnt_d   = pnt_q;
    lbl_d   = lbl_q;
    nnd_d   = nnd_q;
    nnl_d   = nnl_q;
    nnv_d   = nnv_q;
    res_d   = res_q;
    mem_rd  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          qry_d   = query;
          nnd_d   = '1;
          nnl_d   = '0;
          nnv_d   = '0;
          res_d   = '0;
          i_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        pnt_d   = mem_point;
        lbl_d   = mem_label;
        state_d = S_INSERT;
      end
      S_INSERT: begin
        if (ins_found) begin
          nnd_d = sh_dist;
          nnl_d = sh_label;
          nnv_d = sh_valid;
        end
        if (i_q == AW'(N_POINTS - 1)) begin
          state_d = S_VOTE;
        end else begin
          i_d     = i_q + AW'(1);
          state_d = S_FETCH;
        end
      end
      S_VOTE: begin
        res_d   = best_lbl;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      qry_q   <= '0;
      pnt_q   <= '0;
      lbl_q   <= '0;
      nnd_q   <= '1;
      nnl_q   <= '0;
      nnv_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      qry_q   <= qry_d;
      pnt_q   <= pnt_d;
      lbl_q   <= lbl_d;
      nnd_q   <= nnd_d;
      nnl_q   <= nnl_d;
      nnv_q   <= nnv_d;
      res_q   <= res_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign mem_addr     = i_q;
  assign dist_p       = pnt_q;
  assign dist_q       = qry_q;
  assign nn_dist      = nnd_q;
  assign nn_label     = nnl_q;
  assign nn_valid     = nnv_q;
  assign result_label = res_q;

endmodule

// File: doc/knn_query_controller.md
Name: knn_query_controller

Overview:
- Sequences one k-nearest-neighbour classification query over a training set of N_POINTS stored points.
- Fetches each training point from an external read-only memory and drives it, with the latched query, into the external combinational Euclidean distance datapath.
- Keeps a sorted list of the K smallest distances and their labels, then performs a majority vote.
- Sits between the host/query interface and the training-point memory plus distance unit.

Parameters:
- SIZE, 32, bit width of each coordinate and of the distance value.
- DIMENSION, 3, coordinates per point.
- N_POINTS, 16, training points in memory (>=1).
- K, 3, neighbours kept (1 <= K <= N_POINTS).
- LABEL_W, 2, label width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin query; sampled only in IDLE
- query  input  SIZE x DIMENSION  query point; latched on accepted start
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse, results valid
- mem_rd  output  1  memory read strobe
- mem_addr  output  $clog2(N_POINTS) (min 1)  training point index
- mem_point  input  SIZE x DIMENSION  point data, valid the cycle after mem_rd
- mem_label  input  LABEL_W  label, valid with mem_point
- dist_p  output  SIZE x DIMENSION  to distance unit p (registered training point)
- dist_q  output  SIZE x DIMENSION  to distance unit q (latched query)
- dist_val  input  SIZE  combinational distance result
- nn_dist  output  SIZE x K  sorted ascending distances, index 0 nearest
- nn_label  output  LABEL_W x K  labels matching nn_dist
- nn_valid  output  K  entry-valid bits
- result_label  output  LABEL_W  majority-vote label

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active-low. The reset value of every register and output is 0, except nn_dist, which resets to all-ones. State resets to IDLE.
- Reset mid-query: immediate abort to IDLE. No done pulse. The list is cleared.
- FSM states: IDLE, FETCH, LOAD, INSERT, VOTE, DONE.
- IDLE:
  - On start=1, latch query, clear the list (nn_valid=0, nn_dist=all-ones, nn_label=0), set index i=0, then go to FETCH.
  - start is ignored in every other state.
- FETCH: mem_rd=1, mem_addr=i, then go to LOAD.
- LOAD: register mem_point into p_reg and mem_label into l_reg, then go to INSERT. dist_p=p_reg at all times.
- INSERT:
  - Sample dist_val as d.
  - Insertion position j is the lowest index where !nn_valid[j] or d < nn_dist[j]. The compare is strict and unsigned.
  - Equal distances therefore keep the earlier-fetched point nearer.
  - Entries j..K-2 shift to j+1..K-1, and the entry at K-1 is dropped. Write d, l_reg and valid=1 at j.
  - If no j exists, the list is unchanged.
  - If i==N_POINTS-1, go to VOTE; else increment i and go to FETCH.
- VOTE:
  - Count occurrences of each label among the valid entries only.
  - result_label is the label with the highest count. A count tie resolves to the numerically smallest label.
  - Then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Outputs: nn_* and result_label hold until the next accepted start.
- Latency: start sampled at edge 0 puts FETCH(0) in cycle 1. The last INSERT is in cycle 3*N_POINTS, VOTE in 3*N_POINTS+1, and done in 3*N_POINTS+2.
- busy: high in FETCH through DONE inclusive.
- Width rules: dist_val arrives already truncated to SIZE bits. The controller never interprets overflow; it compares unsigned only.

Test Plan:
- Basic query (N_POINTS=4, K=3, query=(0,0,0)):
  - Stimulus: P0=(3,0,0) L1, P1=(1,0,0) L2, P2=(0,2,0) L2, P3=(1,1,1) L0, giving distances 9, 1, 4, 3.
  - Required: nn_dist={1,3,4}, nn_label={2,0,2}, nn_valid=3'b111, result_label=2. done pulses exactly in cycle 14. mem_addr reads 0,1,2,3 with mem_rd high only in FETCH.
- Equal distances (N_POINTS=4, K=3):
  - Stimulus: P0=(2,0,0) L1, P1=(0,2,0) L3, P2=(0,0,2) L0, all distance 4; P3 distance 9.
  - Required: nn_label={1,3,0}, order kept by fetch. Three-way vote tie gives result_label=0.
- Eviction:
  - Stimulus: distances 5, 7, 9, 1 in fetch order.
  - Required: final nn_dist={1,5,7}; the 9 is dropped.
- Start while busy:
  - Stimulus: pulse start in cycles 2 and 5 of a query.
  - Required: no restart, the mem_addr sequence is unchanged, and exactly one done.
- Reset mid-query:
  - Stimulus: deassert rst_n asynchronously during the INSERT of point 2.
  - Required: all outputs immediately reset (busy=0, nn_valid=0, nn_dist=all-ones). No done. A subsequent start completes a normal query.
- Back-to-back queries:
  - Stimulus: assert start in the cycle after done, with a different query.
  - Required: the list clears on acceptance, and the second result is independent of the first.
